// File: rtl/retire_trace_fifo_if.sv
// retire_trace_fifo_if
//   Bundles the retire-event capture bus, the show-ahead read port and the
//   status/counter outputs of retire_trace_fifo.
//   master : trace source / consumer side (drives ev_* and rd_en)
//   slave  : the FIFO itself
//   Parameter DEPTH must match the DEPTH of the attached retire_trace_fifo,
//   because it sizes the count field.
interface retire_trace_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int COUNT_W = $clog2(DEPTH) + 1;

    // capture side
    logic        ev_regwrite;
    logic [3:0]  ev_reg;
    logic [15:0] ev_regdata;
    logic        ev_memread;
    logic        ev_memwrite;
    logic [15:0] ev_addr;
    logic [15:0] ev_memdata;
    logic        ev_halt;

    // read side
    logic        rd_en;
    logic        rd_valid;
    logic [3:0]  rd_flags;
    logic [3:0]  rd_reg;
    logic [15:0] rd_regdata;
    logic [15:0] rd_addr;
    logic [15:0] rd_memdata;

    // status
    logic [COUNT_W-1:0] count;
    logic        full;
    logic        overflow;
    logic [31:0] inst_count;
    logic [31:0] cycle_count;
    logic        halted;
    logic        timeout;

    modport master (
        output ev_regwrite, ev_reg, ev_regdata, ev_memread, ev_memwrite,
               ev_addr, ev_memdata, ev_halt, rd_en,
        input  rd_valid, rd_flags, rd_reg, rd_regdata, rd_addr, rd_memdata,
               count, full, overflow, inst_count, cycle_count, halted, timeout
    );

    modport slave (
        input  ev_regwrite, ev_reg, ev_regdata, ev_memread, ev_memwrite,
               ev_addr, ev_memdata, ev_halt, rd_en,
        output rd_valid, rd_flags, rd_reg, rd_regdata, rd_addr, rd_memdata,
               count, full, overflow, inst_count, cycle_count, halted, timeout
    );
endinterface

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo
//   Captures one 56-bit trace record per retire event (register write,
//   memory write, halt and, optionally, memory read) into a show-ahead FIFO,
//   and keeps retired-instruction and active-cycle counters. Capture and
//   counting stop once a halt has been captured; draining continues.
//
// Ports
//   clk   : clock
//   rst_n : synchronous, active-low reset
//   bus   : retire_trace_fifo_if.slave
//           ev_*        event inputs sampled every edge
//           rd_en       pop request (ignored when empty)
//           rd_valid    head valid; rd_flags {halt,memwrite,memread,regwrite}
//           rd_reg/rd_regdata/rd_addr/rd_memdata  head record fields
//           count/full  occupancy; overflow sticky on a dropped record
//           inst_count  retired instructions (wraps)
//           cycle_count active cycles (saturates); timeout sticky when it
//                       passes CYCLE_LIMIT; halted sticky on halt capture
//
// Configuration
//   TRACE_MEMREAD_EN : when defined, a memory read alone is an event and
//                      rd_flags[1] reports it; otherwise memory reads are
//                      not traced at all. inst_count is unaffected.
module retire_trace_fifo #(
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 100000
) (
    input logic               clk,
    input logic               rst_n,
    retire_trace_fifo_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    typedef struct packed {
        logic [3:0]  flags;     // {halt, memwrite, memread, regwrite}
        logic [3:0]  regNum;
        logic [15:0] regData;
        logic [15:0] addr;
        logic [15:0] memData;
    } record_t;

    record_t             mem [DEPTH];
    logic [PTR_W-1:0]    wrPtr;
    logic [PTR_W-1:0]    rdPtr;
    logic [COUNT_W-1:0]  countReg;
    logic                overflowReg;
    logic                haltedReg;
    logic                timeoutReg;
    logic [31:0]         instCount;
    logic [31:0]         cycleCount;

    logic                isEmpty;
    logic                isFull;
    logic                memreadTerm;
    logic                evEvent;
    logic                instRetire;
    logic                popFire;
    logic                pushFire;
    logic                dropFire;
    record_t             newRec;
    record_t             headRec;

`ifdef TRACE_MEMREAD_EN
    assign memreadTerm = bus.ev_memread;
`else
    // Memory reads are not traced in this build.
    logic unusedMemread;
    assign unusedMemread = bus.ev_memread;
    assign memreadTerm   = 1'b0;
`endif

    assign isEmpty = (countReg == '0);
    assign isFull  = (countReg == COUNT_W'(DEPTH));

    always_comb begin
        instRetire = !haltedReg &&
                     (bus.ev_halt || bus.ev_regwrite || bus.ev_memwrite);
        evEvent    = !haltedReg &&
                     (bus.ev_halt || bus.ev_regwrite || bus.ev_memwrite || memreadTerm);
        popFire    = bus.rd_en && !isEmpty;
        // A full FIFO still accepts a record when the head leaves this edge.
        pushFire   = evEvent && (!isFull || popFire);
        dropFire   = evEvent && isFull && !popFire;

        newRec.flags   = {bus.ev_halt, bus.ev_memwrite, memreadTerm, bus.ev_regwrite};
        newRec.regNum  = bus.ev_reg;
        newRec.regData = bus.ev_regdata;
        newRec.addr    = bus.ev_addr;
        newRec.memData = bus.ev_memdata;
    end

    // Record storage has no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && pushFire) begin
            mem[wrPtr] <= newRec;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
            haltedReg   <= 1'b0;
            timeoutReg  <= 1'b0;
            instCount   <= '0;
            cycleCount  <= '0;
        end else begin
            if (pushFire) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popFire) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushFire, popFire})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase

            if (dropFire) begin
                overflowReg <= 1'b1;
            end
            if (!haltedReg && bus.ev_halt) begin
                haltedReg <= 1'b1;
            end
            if (instRetire) begin
                instCount <= instCount + 32'd1;
            end
            if (!haltedReg && (cycleCount != 32'hFFFF_FFFF)) begin
                cycleCount <= cycleCount + 32'd1;
                // This increment takes the count to CYCLE_LIMIT+1.
                if (cycleCount == 32'(CYCLE_LIMIT)) begin
                    timeoutReg <= 1'b1;
                end
            end
        end
    end

    // Show-ahead: the head slot is read asynchronously so a record written
    // into an empty FIFO is visible the cycle after its push.
    assign headRec = mem[rdPtr];

    assign bus.rd_valid    = !isEmpty;
    assign bus.rd_flags    = isEmpty ? 4'b0000 : headRec.flags;
    assign bus.rd_reg      = headRec.regNum;
    assign bus.rd_regdata  = headRec.regData;
    assign bus.rd_addr     = headRec.addr;
    assign bus.rd_memdata  = headRec.memData;
    assign bus.count       = countReg;
    assign bus.full        = isFull;
    assign bus.overflow    = overflowReg;
    assign bus.inst_count  = instCount;
    assign bus.cycle_count = cycleCount;
    assign bus.halted      = haltedReg;
    assign bus.timeout     = timeoutReg;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb_retire_trace_fifo
//   Directed self-checking bench for retire_trace_fifo (DEPTH=16,
//   CYCLE_LIMIT=30). Inputs change and outputs are sampled 1 time unit after
//   each rising edge. Works with or without TRACE_MEMREAD_EN.
module tb_retire_trace_fifo;
    localparam int DEPTH       = 16;
    localparam int CYCLE_LIMIT = 30;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    retire_trace_fifo_if #(.DEPTH(DEPTH)) bus ();

    retire_trace_fifo #(
        .DEPTH      (DEPTH),
        .CYCLE_LIMIT(CYCLE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearEv();
        bus.ev_regwrite = 1'b0;
        bus.ev_reg      = 4'd0;
        bus.ev_regdata  = 16'd0;
        bus.ev_memread  = 1'b0;
        bus.ev_memwrite = 1'b0;
        bus.ev_addr     = 16'd0;
        bus.ev_memdata  = 16'd0;
        bus.ev_halt     = 1'b0;
        bus.rd_en       = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearEv();
        step();
        rst_n = 1'b1;
    endtask

    task automatic pushMemwrite(input logic [15:0] a);
        bus.ev_memwrite = 1'b1;
        bus.ev_addr     = a;
        bus.ev_memdata  = a ^ 16'h5A00;
        step();
        clearEv();
    endtask

    task automatic pushRegwrite(input logic [3:0] r, input logic [15:0] d);
        bus.ev_regwrite = 1'b1;
        bus.ev_reg      = r;
        bus.ev_regdata  = d;
        step();
        clearEv();
    endtask

    task automatic drainExpect(input string tag, input logic [15:0] a);
        checkVal({tag, ".valid"}, 32'(bus.rd_valid), 32'd1);
        checkVal({tag, ".addr"}, 32'(bus.rd_addr), 32'(a));
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        clearEv();

        // Reset state after two reset cycles
        step();
        step();
        checkVal("rst.rd_valid", 32'(bus.rd_valid), 32'd0);
        checkVal("rst.count", 32'(bus.count), 32'd0);
        checkVal("rst.full", 32'(bus.full), 32'd0);
        checkVal("rst.rd_flags", 32'(bus.rd_flags), 32'd0);
        checkVal("rst.overflow", 32'(bus.overflow), 32'd0);
        checkVal("rst.inst_count", bus.inst_count, 32'd0);
        checkVal("rst.cycle_count", bus.cycle_count, 32'd0);
        checkVal("rst.halted", 32'(bus.halted), 32'd0);
        checkVal("rst.timeout", 32'(bus.timeout), 32'd0);

        // Single register write captured on the first edge out of reset
        rst_n = 1'b1;
        pushRegwrite(4'd3, 16'h1234);
        checkVal("rw.rd_valid", 32'(bus.rd_valid), 32'd1);
        checkVal("rw.rd_flags", 32'(bus.rd_flags), 32'b0001);
        checkVal("rw.rd_reg", 32'(bus.rd_reg), 32'd3);
        checkVal("rw.rd_regdata", 32'(bus.rd_regdata), 32'h1234);
        checkVal("rw.inst_count", bus.inst_count, 32'd1);
        checkVal("rw.cycle_count", bus.cycle_count, 32'd1);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checkVal("rw.pop.rd_valid", 32'(bus.rd_valid), 32'd0);
        checkVal("rw.pop.rd_flags", 32'(bus.rd_flags), 32'd0);
        checkVal("rw.pop.cycle_count", bus.cycle_count, 32'd2);

        // Memory-read-only cycle
        bus.ev_memread = 1'b1;
        bus.ev_addr    = 16'h0040;
        step();
        clearEv();
        checkVal("mr.inst_count", bus.inst_count, 32'd1);
`ifdef TRACE_MEMREAD_EN
        checkVal("mr.count", 32'(bus.count), 32'd1);
        checkVal("mr.rd_flags", 32'(bus.rd_flags), 32'b0010);
        checkVal("mr.rd_addr", 32'(bus.rd_addr), 32'h0040);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
`else
        checkVal("mr.count", 32'(bus.count), 32'd0);
        checkVal("mr.rd_valid", 32'(bus.rd_valid), 32'd0);
`endif

        // Pop on empty is ignored
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checkVal("emptypop.count", 32'(bus.count), 32'd0);

        // Push and pop together at count=1: head replaced, count unchanged
        pushRegwrite(4'd7, 16'h0007);
        bus.ev_regwrite = 1'b1;
        bus.ev_reg      = 4'd8;
        bus.ev_regdata  = 16'h0008;
        bus.rd_en       = 1'b1;
        step();
        clearEv();
        checkVal("pp1.count", 32'(bus.count), 32'd1);
        checkVal("pp1.rd_reg", 32'(bus.rd_reg), 32'd8);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;

        // Fill to exactly full, then push+pop at full
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            pushMemwrite(16'(i));
        end
        checkVal("fill.full", 32'(bus.full), 32'd1);
        checkVal("fill.count", 32'(bus.count), 32'd16);
        checkVal("fill.overflow", 32'(bus.overflow), 32'd0);
        checkVal("fill.rd_flags", 32'(bus.rd_flags), 32'b0100);
        checkVal("fill.rd_memdata", 32'(bus.rd_memdata), 32'h5A00);
        bus.ev_memwrite = 1'b1;
        bus.ev_addr     = 16'h00AA;
        bus.rd_en       = 1'b1;
        step();
        clearEv();
        checkVal("ppfull.count", 32'(bus.count), 32'd16);
        checkVal("ppfull.overflow", 32'(bus.overflow), 32'd0);
        checkVal("ppfull.inst_count", bus.inst_count, 32'd17);
        for (int i = 1; i < DEPTH; i++) begin
            drainExpect($sformatf("ppfull.drain%0d", i), 16'(i));
        end
        drainExpect("ppfull.drainLast", 16'h00AA);
        checkVal("ppfull.empty", 32'(bus.rd_valid), 32'd0);

        // Overflow: 17 writes with no pops
        doReset();
        for (int i = 0; i <= DEPTH; i++) begin
            pushMemwrite(16'(i));
        end
        checkVal("ovf.full", 32'(bus.full), 32'd1);
        checkVal("ovf.count", 32'(bus.count), 32'd16);
        checkVal("ovf.overflow", 32'(bus.overflow), 32'd1);
        checkVal("ovf.inst_count", bus.inst_count, 32'd17);
        for (int i = 0; i < DEPTH; i++) begin
            drainExpect($sformatf("ovf.drain%0d", i), 16'(i));
        end
        checkVal("ovf.empty", 32'(bus.rd_valid), 32'd0);
        checkVal("ovf.full_after", 32'(bus.full), 32'd0);

        // Reset with 5 records held
        doReset();
        for (int i = 0; i < 5; i++) begin
            pushRegwrite(4'(i), 16'(i));
        end
        checkVal("rst5.count_before", 32'(bus.count), 32'd5);
        rst_n = 1'b0;
        bus.ev_regwrite = 1'b1;    // reset must win over a simultaneous push
        step();
        clearEv();
        rst_n = 1'b1;
        checkVal("rst5.count", 32'(bus.count), 32'd0);
        checkVal("rst5.rd_valid", 32'(bus.rd_valid), 32'd0);
        checkVal("rst5.inst_count", bus.inst_count, 32'd0);
        checkVal("rst5.cycle_count", bus.cycle_count, 32'd0);

        // Halt together with a register write, then further events ignored
        bus.ev_halt     = 1'b1;
        bus.ev_regwrite = 1'b1;
        bus.ev_reg      = 4'd5;
        bus.ev_regdata  = 16'h0055;
        step();
        clearEv();
        checkVal("halt.halted", 32'(bus.halted), 32'd1);
        checkVal("halt.count", 32'(bus.count), 32'd1);
        checkVal("halt.rd_flags", 32'(bus.rd_flags), 32'b1001);
        pushRegwrite(4'd1, 16'h0001);
        pushMemwrite(16'h0002);
        bus.ev_halt = 1'b1;
        step();
        clearEv();
        checkVal("halt.count_after", 32'(bus.count), 32'd1);
        checkVal("halt.inst_count", bus.inst_count, 32'd1);
        checkVal("halt.cycle_count", bus.cycle_count, 32'd1);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        checkVal("halt.drained", 32'(bus.rd_valid), 32'd0);

        // Timeout boundary at CYCLE_LIMIT
        doReset();
        for (int i = 0; i < CYCLE_LIMIT; i++) begin
            step();
        end
        checkVal("tmo.cycle_at_limit", bus.cycle_count, 32'(CYCLE_LIMIT));
        checkVal("tmo.not_yet", 32'(bus.timeout), 32'd0);
        step();
        checkVal("tmo.cycle_past", bus.cycle_count, 32'(CYCLE_LIMIT + 1));
        checkVal("tmo.set", 32'(bus.timeout), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/retire_trace_fifo.md
RETIRE_TRACE_FIFO -- requirements
Module: retire_trace_fifo

Interface
REQ-001 Parameters:
- DEPTH, 16, number of record slots (power of 2, ≥2).
- CYCLE_LIMIT, 100000, cycle count above which timeout asserts.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- ev_regwrite  in  1  register file written this cycle.
- ev_reg  in  4  destination register.
- ev_regdata  in  16  register write data.
- ev_memread  in  1  data memory read this cycle.
- ev_memwrite  in  1  data memory write this cycle.
- ev_addr  in  16  data memory address.
- ev_memdata  in  16  memory data (store data or load data).
- ev_halt  in  1  halt reached memory/writeback.
- rd_en  in  1  pop request.
- rd_valid  out  1  head record valid (FIFO not empty).
- rd_flags  out  4  head {halt, memwrite, memread, regwrite}.
- rd_reg  out  4  head register.
- rd_regdata  out  16  head register data.
- rd_addr  out  16  head address.
- rd_memdata  out  16  head memory data.
- count  out  log2(DEPTH)+1  records held.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: record dropped.
- inst_count  out  32  retired-instruction count.
- cycle_count  out  32  active-cycle count.
- halted  out  1  sticky: halt captured.
- timeout  out  1  sticky: cycle_count > CYCLE_LIMIT.

Function
REQ-003 Capture: on each clk edge where not halted, event = ev_regwrite|ev_memwrite|ev_halt|ev_memread (the ev_memread term exists only under REQ-017). An event builds one 56-bit record from all ev_* inputs sampled that edge.
REQ-004 A record is pushed when event is true and the FIFO is not full, or when full but popped that same edge.
REQ-005 When event is true, the FIFO is full, and there is no same-edge pop, the record is dropped and overflow sets. Nothing already stored is modified.
REQ-006 Read: show-ahead. rd_* reflect the head whenever rd_valid=1. rd_en while rd_valid=1 pops the head at the edge. rd_en while empty is ignored.
REQ-007 Push and pop on the same edge: count unchanged. Applies at full and at count=1. From empty, push-only makes the record visible on rd_* the following cycle (latency 1).
REQ-008 Read and write pointers wrap modulo DEPTH. count, full and rd_valid are registered-consistent every cycle.
REQ-009 inst_count increments by 1 per edge where not halted and (ev_halt|ev_regwrite|ev_memwrite). It increments even if the record is dropped, and wraps at 2^32.
REQ-010 cycle_count increments by 1 each edge while not halted, saturating at 2^32-1. timeout sets on the edge where cycle_count becomes CYCLE_LIMIT+1.
REQ-011 Halt: ev_halt with not halted sets halted. The halt record is pushed per REQ-004 and counted per REQ-009.
REQ-012 After halted=1: ev_* are ignored and counters freeze. Popping continues until empty.
REQ-013 When rd_valid=0, rd_* data outputs are don't-care; rd_flags reads 0.

Reset
REQ-014 rst_n=0 at an edge clears pointers, count, overflow, halted, timeout, inst_count and cycle_count. Outputs: rd_valid=0, full=0, count=0, rd_flags=0.
REQ-015 Reset has priority over simultaneous push/pop/halt. Reset mid-drain discards all stored records. Storage array contents need not be cleared.
REQ-016 The first capture occurs on the first edge with rst_n=1.

Configuration
REQ-017 Macro TRACE_MEMREAD_EN.
- Defined: ev_memread alone constitutes an event, and rd_flags[1] carries ev_memread.
- Undefined: ev_memread is ignored, rd_flags[1] is always 0, and memread-only cycles push nothing.
- inst_count is unaffected by the macro in both cases.

Verification
REQ-018 Reset 2 cycles, then ev_regwrite=1, ev_reg=3, ev_regdata=0x1234 for one cycle. Required next cycle: rd_valid=1, rd_flags=0001, rd_reg=3, rd_regdata=0x1234, inst_count=1.
REQ-019 With DEPTH=16 and no pops, 17 consecutive ev_memwrite cycles (ev_addr=i). Required: full=1, count=16, overflow=1, inst_count=17. Draining returns addr 0..15 in order.
REQ-020 At full, a push and rd_en on the same edge. Required: count stays 16, overflow stays 0, and the new record appears last on drain.
REQ-021 ev_halt with ev_regwrite together, then 3 further events. Required: halted=1, a single record with flags=1001, and inst_count and cycle_count frozen.
REQ-022 ev_memread-only cycle with ev_addr=0x0040. Required: with TRACE_MEMREAD_EN, a record with flags=0010 and inst_count unchanged; without the macro, no record.
REQ-023 Assert rst_n=0 with 5 records held. Required next cycle: count=0, rd_valid=0, counters 0.
